// File: rtl/reply_arbiter_if.sv
// Source byte lanes plus the shared host reply channel. The arbiter side uses the
// master modport; the handlers and host side use slave.
interface reply_arbiter_if #(
  parameter int unsigned N_SRC = 6
);
  logic [N_SRC-1:0]   src_rdy;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_last;
  logic [N_SRC-1:0]   src_ack;
  logic               reply_rdy;
  logic [7:0]         reply;
  logic               reply_ack;
  logic               reply_end;

  modport master (
    input  src_rdy, src_data, src_last, reply_ack,
    output src_ack, reply_rdy, reply, reply_end
  );

  modport slave (
    output src_rdy, src_data, src_last, reply_ack,
    input  src_ack, reply_rdy, reply, reply_end
  );
endinterface

// File: rtl/reply_arbiter.sv
// Round-robin arbiter sharing the host reply byte channel among N_SRC packet sources,
// with a one-entry output register, packet length cap and mid-packet stall timeout.
module reply_arbiter #(
  parameter int unsigned N_SRC   = 6,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  reply_arbiter_if.master     bus,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                overflow_err,
  output logic                timeout_err
);

  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StFlush, StDrain} state_e;

  state_e              state;
  logic [2:0]          grant;
  logic [2:0]          last_grant;
  logic [7:0]          byte_cnt;
  logic [StallW-1:0]   stall_cnt;
  logic [7:0]          reply_q;
  logic                reply_rdy_q;
  logic                reply_end_q;

  logic                buf_free;
  logic                any_req;
  logic                at_max;
  logic                src_rdy_g;
  logic                src_last_g;
  logic [7:0]          src_byte_g;
  logic [2:0]          next_grant;
  logic [N_SRC-1:0]    src_ack_v;

  assign buf_free = ~reply_rdy_q | bus.reply_ack;
  assign any_req  = |bus.src_rdy;
  assign at_max   = (byte_cnt == 8'(MAX_LEN - 1));

  always_comb begin
    src_rdy_g  = 1'b0;
    src_last_g = 1'b0;
    src_byte_g = 8'h00;
    src_ack_v  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (3'(i) == grant) begin
        src_rdy_g  = bus.src_rdy[i];
        src_last_g = bus.src_last[i];
        src_byte_g = bus.src_data[8*i +: 8];
        src_ack_v[i] = bus.src_rdy[i] &
                       (((state == StXfer) & buf_free) | (state == StFlush));
      end
    end
  end

  // Round robin: sources above last_grant first, then wrap to the low ones.
  always_comb begin
    logic found;
    found      = 1'b0;
    next_grant = last_grant;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!found && bus.src_rdy[i] && (3'(i) > last_grant)) begin
        found      = 1'b1;
        next_grant = 3'(i);
      end
    end
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!found && bus.src_rdy[i] && (3'(i) <= last_grant)) begin
        found      = 1'b1;
        next_grant = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      grant        <= 3'd0;
      last_grant   <= 3'(N_SRC - 1);
      byte_cnt     <= 8'd0;
      stall_cnt    <= '0;
      reply_q      <= 8'h00;
      reply_rdy_q  <= 1'b0;
      reply_end_q  <= 1'b0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
      if (reply_rdy_q && bus.reply_ack) begin
        reply_rdy_q <= 1'b0;
        reply_end_q <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (any_req) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            byte_cnt   <= 8'd0;
            stall_cnt  <= '0;
            state      <= StXfer;
          end
        end
        StXfer: begin
          if (buf_free) begin
            if (src_rdy_g) begin
              reply_q     <= src_byte_g;
              reply_rdy_q <= 1'b1;
              reply_end_q <= src_last_g | at_max;
              byte_cnt    <= byte_cnt + 8'd1;
              stall_cnt   <= '0;
              if (src_last_g) begin
                state <= StDrain;
              end else if (at_max) begin
                overflow_err <= 1'b1;
                state        <= StFlush;
              end
            end else if (stall_cnt == StallW'(TIMEOUT - 1)) begin
              // Close the packet with a marker byte so the host sees a clean end.
              reply_q     <= 8'hEE;
              reply_rdy_q <= 1'b1;
              reply_end_q <= 1'b1;
              timeout_err <= 1'b1;
              state       <= StDrain;
            end else begin
              stall_cnt <= stall_cnt + StallW'(1);
            end
          end
        end
        StFlush: begin
          if (src_rdy_g && src_last_g) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (buf_free) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.src_ack   = src_ack_v;
  assign bus.reply     = reply_q;
  assign bus.reply_rdy = reply_rdy_q;
  assign bus.reply_end = reply_end_q;
  assign busy          = (state != StIdle) | reply_rdy_q;
  assign grant_id      = grant;

endmodule

// File: tb/tb_reply_arbiter.sv
// Scoreboard bench for reply_arbiter: source packet queues drive the lanes, expected
// {grant, end, byte} words are queued at stimulus time and popped on each host handshake.
module tb_reply_arbiter;

  localparam int unsigned N  = 6;
  localparam int unsigned ML = 64;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [2:0] grant_id;
  logic       overflow_err;
  logic       timeout_err;

  always #5 clk = ~clk;

  reply_arbiter_if #(.N_SRC(N)) bus ();

  reply_arbiter #(
    .N_SRC  (N),
    .MAX_LEN(ML),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .overflow_err(overflow_err),
    .timeout_err (timeout_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ack_lo  = -1;
  int          ack_hi  = -1;
  logic [11:0] sb[$];
  logic [8:0]  src_mem[N][256];
  int          head[N];
  int          tail[N];
  int          ovf_cnt, to_cnt, first_fire, last_fire, prev_fire;
  logic        prev_hold = 1'b0;
  logic [9:0]  prev_val  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_src(input int s, input int d, input int l);
    if (head[s] == tail[s]) begin
      head[s] = 0;
      tail[s] = 0;
    end
    src_mem[s][tail[s]] = {l[0], d[7:0]};
    tail[s]++;
  endtask

  task automatic push_exp(input int g, input int e, input int d);
    sb.push_back({g[2:0], e[0], d[7:0]});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < int'(N); i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_srcs();
    logic [N-1:0]   r = '0;
    logic [N-1:0]   l = '0;
    logic [8*N-1:0] d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (head[i] != tail[i]) begin
        r[i]        = 1'b1;
        l[i]        = src_mem[i][head[i]][8];
        d[8*i +: 8] = src_mem[i][head[i]][7:0];
      end
    end
    bus.src_rdy  = r;
    bus.src_last = l;
    bus.src_data = d;
  endtask

  task automatic start_test();
    ovf_cnt    = 0;
    to_cnt     = 0;
    first_fire = -1;
    last_fire  = -1;
    prev_fire  = -1;
  endtask

  // One clock: observe at the falling edge, update stimulus just after the rising edge.
  task automatic step();
    logic [N-1:0] ack_seen;
    logic [11:0]  exp;
    @(negedge clk);
    cyc++;
    if (prev_hold)
      check("hold", 32'({bus.reply_rdy, bus.reply_end, bus.reply}), 32'(prev_val));
    prev_hold = bus.reply_rdy & ~bus.reply_ack;
    prev_val  = {bus.reply_rdy, bus.reply_end, bus.reply};
    if (bus.reply_rdy && bus.reply_ack) begin
      if (sb.size() == 0) begin
        check("reply_unexpected", 32'(sb.size()), 32'(1));
      end else begin
        exp = sb.pop_front();
        check("reply", 32'({grant_id, bus.reply_end, bus.reply}), 32'(exp));
      end
      prev_fire = last_fire;
      last_fire = cyc;
      if (first_fire < 0) first_fire = cyc;
    end
    if (|bus.src_ack) check("ack_onehot", 32'($countones(bus.src_ack)), 32'(1));
    ack_seen = bus.src_ack;
    if (overflow_err) ovf_cnt++;
    if (timeout_err)  to_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (ack_seen[i] && head[i] != tail[i]) head[i]++;
    bus.reply_ack = !(cyc >= ack_lo && cyc < ack_hi);
    drive_srcs();
  endtask

  task automatic run(input int max_cyc, input string tag);
    int n = 0;
    while ((sb.size() != 0 || !srcs_empty()) && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_budget"}, 32'(n < max_cyc), 32'(1));
    if (n >= max_cyc) begin
      sb.delete();
      for (int i = 0; i < int'(N); i++) head[i] = tail[i];
      drive_srcs();
    end
    step();
    check({tag, "_idle"}, 32'({busy, bus.reply_rdy}), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.src_rdy   = '1;
    bus.src_data  = '0;
    bus.src_last  = '0;
    bus.reply_ack = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #2;
    check("rst_out", 32'({bus.reply_rdy, bus.reply_end, bus.reply, busy, grant_id,
                          overflow_err, timeout_err}), 32'(0));
    check("rst_ack", 32'(bus.src_ack), 32'(0));
    bus.src_rdy = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single 3-byte packet from source 0, host always ready.
    start_test();
    push_src(0, 'h11, 0); push_src(0, 'h22, 0); push_src(0, 'h33, 1);
    push_exp(0, 0, 'h11); push_exp(0, 0, 'h22); push_exp(0, 1, 'h33);
    drive_srcs();
    run(50, "single");
    check("single_span", 32'(last_fire - first_fire), 32'(2));

    // Sources 1 and 3 each queue two 2-byte packets: grants must alternate.
    start_test();
    for (int p = 0; p < 2; p++) begin
      for (int s = 1; s <= 3; s += 2) begin
        push_src(s, s * 16 + p * 2, 0);     push_exp(s, 0, s * 16 + p * 2);
        push_src(s, s * 16 + p * 2 + 1, 1); push_exp(s, 1, s * 16 + p * 2 + 1);
      end
    end
    drive_srcs();
    run(100, "rr");
    check("rr_span", 32'(last_fire - first_fire), 32'(13));

    // Host withholds reply_ack for 5 cycles in the middle of a 6-byte packet.
    start_test();
    for (int i = 0; i < 6; i++) begin
      push_src(4, 'h60 + i, (i == 5) ? 1 : 0);
      push_exp(4, (i == 5) ? 1 : 0, 'h60 + i);
    end
    ack_lo = cyc + 4;
    ack_hi = ack_lo + 5;
    drive_srcs();
    run(100, "bp");
    check("bp_span", 32'(last_fire - first_fire), 32'(10));
    ack_lo = -1;
    ack_hi = -1;

    // Truncation: source 2 sends 70 bytes; sources 5 and 0 win first by rotation.
    start_test();
    push_src(5, 'h50, 0); push_src(5, 'h51, 1);
    push_src(0, 'h0A, 1);
    for (int i = 0; i < 70; i++) push_src(2, 128 + i, (i == 69) ? 1 : 0);
    push_src(2, 'hC5, 1);
    push_exp(5, 0, 'h50); push_exp(5, 1, 'h51);
    push_exp(0, 1, 'h0A);
    for (int i = 0; i < 64; i++) push_exp(2, (i == 63) ? 1 : 0, 128 + i);
    push_exp(2, 1, 'hC5);
    drive_srcs();
    run(400, "trunc");
    check("trunc_ovf", 32'(ovf_cnt), 32'(1));
    check("trunc_tmo", 32'(to_cnt), 32'(0));

    // Exactly MAX_LEN bytes with last on the final byte is a normal packet.
    start_test();
    for (int i = 0; i < 64; i++) begin
      push_src(1, i, (i == 63) ? 1 : 0);
      push_exp(1, (i == 63) ? 1 : 0, i);
    end
    drive_srcs();
    run(200, "exact");
    check("exact_ovf", 32'(ovf_cnt), 32'(0));

    // Source 0 stalls after two bytes without last: marker byte after TO stall cycles.
    start_test();
    push_src(0, 'hA1, 0); push_src(0, 'hA2, 0);
    push_exp(0, 0, 'hA1); push_exp(0, 0, 'hA2); push_exp(0, 1, 'hEE);
    drive_srcs();
    run(100, "tmo");
    check("tmo_pulse", 32'(to_cnt), 32'(1));
    check("tmo_gap", 32'(last_fire - prev_fire), 32'(16));
    check("tmo_ovf", 32'(ovf_cnt), 32'(0));

    // Reset while byte 2 of a 4-byte packet from source 3 sits on the reply.
    start_test();
    for (int i = 0; i < 4; i++) push_src(3, 'hB0 + i, (i == 3) ? 1 : 0);
    push_exp(3, 0, 'hB0);
    drive_srcs();
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("rst_reach", 32'(sb.size()), 32'(0));
    check("rst_pre_rdy", 32'(bus.reply_rdy), 32'(1));
    check("rst_pre_ack", 32'(bus.src_ack), 32'(8));
    reset = 1'b1;
    #1;
    check("rst_mid_out", 32'({bus.reply_rdy, bus.reply_end, bus.reply, busy, grant_id}),
          32'(0));
    check("rst_mid_ack", 32'(bus.src_ack), 32'(0));
    head[3] = tail[3];
    drive_srcs();
    step();
    reset = 1'b0;
    start_test();
    push_src(1, 'hC1, 1); push_src(4, 'hC4, 1); push_src(0, 'hC0, 1);
    push_exp(0, 1, 'hC0); push_exp(1, 1, 'hC1); push_exp(4, 1, 'hC4);
    drive_srcs();
    run(100, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
